// File: rtl/spi_fifo_param_if.sv
// Bus bundle for spi_fifo_param: write/read handshake, status and error flags.
// The master modport is the register-interface / shift-engine side; the slave
// modport is the FIFO itself. Signal names keep the original port names.
interface spi_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush_i;
  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              rd_en_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic [ADDR_W:0]   count_o;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   thresh_i;
  logic              thresh_o;
  logic              clr_err_i;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output flush_i, wr_en_i, wr_data_i, rd_en_i, thresh_i, clr_err_i,
    input  rd_data_o, rd_valid_o, count_o, full_o, empty_o, thresh_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_en_i, wr_data_i, rd_en_i, thresh_i, clr_err_i,
    output rd_data_o, rd_valid_o, count_o, full_o, empty_o, thresh_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/spi_fifo_param.sv
// Parametrised synchronous FIFO for the SPI TX/RX data paths.
// Concurrent read/write on full, threshold flag, sticky overflow/underflow
// flags and synchronous flush. Storage is not reset.
// Build option: define SPI_FIFO_FWFT_EN for first-word-fall-through reads
// (zero read latency); default is a registered read with 1-cycle latency.
module spi_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  spi_fifo_param_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf;
  logic              udf;

  assign full   = (count == (ADDR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  // A read on empty is never accepted, even alongside a write (no bypass).
  assign rd_acc = bus.rd_en_i & ~empty;
  // On full, a write only fits if a read frees a slot in the same cycle.
  assign wr_acc = bus.wr_en_i & (~full | rd_acc);

  // Storage write; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!bus.flush_i && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data_i;
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle read/write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_acc && !rd_acc) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - (ADDR_W+1)'(1);
      end
    end
  end

  // Sticky error flags: a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (!bus.flush_i && bus.wr_en_i && full && !rd_acc) begin
        ovf <= 1'b1;
      end else if (bus.clr_err_i) begin
        ovf <= 1'b0;
      end
      if (!bus.flush_i && bus.rd_en_i && empty) begin
        udf <= 1'b1;
      end else if (bus.clr_err_i) begin
        udf <= 1'b0;
      end
    end
  end

`ifdef SPI_FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en_i pops it.
  assign bus.rd_data_o  = mem[rd_ptr];
  assign bus.rd_valid_o = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Registered read: data appears the cycle after an accepted read and then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc & ~bus.flush_i;
      if (rd_acc && !bus.flush_i) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
`endif

  assign bus.count_o     = count;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.thresh_o    = (count >= bus.thresh_i);
  assign bus.overflow_o  = ovf;
  assign bus.underflow_o = udf;

endmodule

// File: tb/tb_spi_fifo_param.sv
// Directed self-checking bench for spi_fifo_param (DATA_W=8, DEPTH=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
module tb_spi_fifo_param;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  spi_fifo_param_if #(.DATA_W(8), .DEPTH(8)) bus ();

  spi_fifo_param #(.DATA_W(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = d;
    tick();
    bus.wr_en_i   = 1'b0;
  endtask

  // Returns the word delivered by one read request and its valid qualifier.
  task automatic pop(output logic [7:0] d, output logic v);
`ifdef SPI_FIFO_FWFT_EN
    d = bus.rd_data_o;
    v = bus.rd_valid_o;
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
`else
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    d = bus.rd_data_o;
    v = bus.rd_valid_o;
`endif
  endtask

  task automatic clear_all();
    bus.flush_i   = 1'b1;
    bus.clr_err_i = 1'b1;
    tick();
    bus.flush_i   = 1'b0;
    bus.clr_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count_o); end
    vectors++;
    if (bus.empty_o !== 1'b1 || bus.full_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", bus.empty_o, bus.full_o);
    end
    vectors++;
    if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.rd_valid_o); end
    vectors++;
    if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      errors++; $display("FAIL reset_err ovf=%b udf=%b exp 0 0", bus.overflow_o, bus.underflow_o);
    end
    vectors++;
    if (bus.thresh_o !== 1'b1) begin errors++; $display("FAIL reset_thresh0 got %b exp 1", bus.thresh_o); end
`ifndef SPI_FIFO_FWFT_EN
    vectors++;
    if (bus.rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.rd_data_o); end
`endif
  endtask

  task automatic test_fill_drain();
    logic [7:0] d;
    logic       v;
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
    vectors++;
    if (bus.full_o !== 1'b1 || bus.count_o !== 4'd8) begin
      errors++; $display("FAIL fill_full full=%b count=%0d exp 1 8", bus.full_o, bus.count_o);
    end
    for (int i = 1; i <= 8; i++) begin
      pop(d, v);
      vectors++;
      if (d !== 8'(8'h11 * i) || v !== 1'b1) begin
        errors++; $display("FAIL drain_%0d data=%h valid=%b exp %h 1", i, d, v, 8'(8'h11 * i));
      end
    end
    tick();
    vectors++;
    if (bus.empty_o !== 1'b1 || bus.rd_valid_o !== 1'b0) begin
      errors++; $display("FAIL drain_end empty=%b valid=%b exp 1 0", bus.empty_o, bus.rd_valid_o);
    end
  endtask

  task automatic test_rw_on_full();
    logic [7:0] d;
    logic       v;
    for (int i = 1; i <= 8; i++) push(8'(i));
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = 8'hAA;
    bus.rd_en_i   = 1'b1;
`ifdef SPI_FIFO_FWFT_EN
    d = bus.rd_data_o;
    v = bus.rd_valid_o;
    tick();
`else
    tick();
    d = bus.rd_data_o;
    v = bus.rd_valid_o;
`endif
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    vectors++;
    if (d !== 8'h01 || v !== 1'b1) begin errors++; $display("FAIL rwfull_data got %h/%b exp 01/1", d, v); end
    vectors++;
    if (bus.count_o !== 4'd8 || bus.overflow_o !== 1'b0) begin
      errors++; $display("FAIL rwfull_state count=%0d ovf=%b exp 8 0", bus.count_o, bus.overflow_o);
    end
    for (int i = 2; i <= 9; i++) begin
      pop(d, v);
      vectors++;
      if (d !== ((i == 9) ? 8'hAA : 8'(i))) begin
        errors++; $display("FAIL rwfull_drain_%0d got %h exp %h", i, d, (i == 9) ? 8'hAA : 8'(i));
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    push(8'hEE);
    vectors++;
    if (bus.overflow_o !== 1'b1 || bus.count_o !== 4'd8) begin
      errors++; $display("FAIL ovf_set ovf=%b count=%0d exp 1 8", bus.overflow_o, bus.count_o);
    end
    for (int i = 0; i < 8; i++) begin
      pop(d, v);
      vectors++;
      if (d !== 8'(8'h20 + i)) begin errors++; $display("FAIL ovf_contents_%0d got %h exp %h", i, d, 8'(8'h20 + i)); end
    end
    vectors++;
    if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow_o); end
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    vectors++;
    if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow_o); end
  endtask

  task automatic test_underflow();
    logic [7:0] d;
    logic       v;
    pop(d, v);
    vectors++;
    if (bus.underflow_o !== 1'b1 || v !== 1'b0) begin
      errors++; $display("FAIL udf udf=%b valid=%b exp 1 0", bus.underflow_o, v);
    end
    vectors++;
    if (bus.count_o !== 4'd0) begin errors++; $display("FAIL udf_count got %0d exp 0", bus.count_o); end
    clear_all();
  endtask

  task automatic test_err_priority();
    for (int i = 0; i < 8; i++) push(8'(i));
    bus.clr_err_i = 1'b1;
    push(8'h55);
    bus.clr_err_i = 1'b0;
    vectors++;
    if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b exp 1", bus.overflow_o); end
    clear_all();
    vectors++;
    if (bus.overflow_o !== 1'b0 || bus.count_o !== 4'd0) begin
      errors++; $display("FAIL prio_cleanup ovf=%b count=%0d exp 0 0", bus.overflow_o, bus.count_o);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic       v;
    int         exp_next;
    exp_next = 0;
    for (int i = 0; i < 20; i++) begin
      push(8'(i));
      if (i >= 2) begin
        pop(d, v);
        vectors++;
        if (d !== 8'(exp_next)) begin errors++; $display("FAIL wrap_%0d got %h exp %h", exp_next, d, 8'(exp_next)); end
        exp_next++;
      end
    end
    while (exp_next < 20) begin
      pop(d, v);
      vectors++;
      if (d !== 8'(exp_next)) begin errors++; $display("FAIL wrap_%0d got %h exp %h", exp_next, d, 8'(exp_next)); end
      exp_next++;
    end
    vectors++;
    if (bus.empty_o !== 1'b1 || bus.underflow_o !== 1'b0) begin
      errors++; $display("FAIL wrap_end empty=%b udf=%b exp 1 0", bus.empty_o, bus.underflow_o);
    end
  endtask

  task automatic test_thresh();
    bus.thresh_i = 4'd5;
    for (int i = 0; i < 4; i++) push(8'(i));
    vectors++;
    if (bus.thresh_o !== 1'b0 || bus.count_o !== 4'd4) begin
      errors++; $display("FAIL thresh_4 thr=%b count=%0d exp 0 4", bus.thresh_o, bus.count_o);
    end
    push(8'h04);
    vectors++;
    if (bus.thresh_o !== 1'b1 || bus.count_o !== 4'd5) begin
      errors++; $display("FAIL thresh_5 thr=%b count=%0d exp 1 5", bus.thresh_o, bus.count_o);
    end
    bus.thresh_i = 4'd0;
    clear_all();
  endtask

  task automatic test_flush();
    logic [7:0] d;
    logic       v;
    for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
    bus.flush_i   = 1'b1;
    bus.wr_en_i   = 1'b1;
    bus.rd_en_i   = 1'b1;
    bus.wr_data_i = 8'h99;
    tick();
    bus.flush_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    vectors++;
    if (bus.count_o !== 4'd0 || bus.empty_o !== 1'b1 || bus.rd_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_state count=%0d empty=%b valid=%b exp 0 1 0", bus.count_o, bus.empty_o, bus.rd_valid_o);
    end
    vectors++;
    if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      errors++; $display("FAIL flush_err ovf=%b udf=%b exp 0 0", bus.overflow_o, bus.underflow_o);
    end
    push(8'h5A);
    pop(d, v);
    vectors++;
    if (d !== 8'h5A || v !== 1'b1) begin errors++; $display("FAIL flush_after got %h/%b exp 5A/1", d, v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       v;
    push(8'h61);
    push(8'h62);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (bus.count_o !== 4'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", bus.count_o); end
    push(8'h77);
    pop(d, v);
    vectors++;
    if (d !== 8'h77) begin errors++; $display("FAIL rst_mid_data got %h exp 77", d); end
  endtask

`ifdef SPI_FIFO_FWFT_EN
  task automatic test_fwft();
    push(8'h3C);
    vectors++;
    if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 8'h3C) begin
      errors++; $display("FAIL fwft_show valid=%b data=%h exp 1 3C", bus.rd_valid_o, bus.rd_data_o);
    end
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    vectors++;
    if (bus.empty_o !== 1'b1 || bus.rd_valid_o !== 1'b0) begin
      errors++; $display("FAIL fwft_pop empty=%b valid=%b exp 1 0", bus.empty_o, bus.rd_valid_o);
    end
  endtask
`endif

  initial begin
    vectors       = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.flush_i   = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.wr_data_i = '0;
    bus.rd_en_i   = 1'b0;
    bus.thresh_i  = '0;
    bus.clr_err_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_rw_on_full();
    test_overflow();
    test_underflow();
    test_err_priority();
    test_wrap();
    test_thresh();
    test_flush();
    test_reset_mid();
`ifdef SPI_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
